// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: one handshaked bus transaction per load/store,
// with load alignment/extension. Optional misalignment trap: define MISALIGN_EXC_EN.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        In_MemRead,
  input  logic        In_MemWrite,
  input  logic [1:0]  In_MemSize,
  input  logic        In_MemSigned,
  input  logic [31:0] In_Address,
  input  logic [31:0] In_Store_Data,
  output logic        Mem_Req,
  output logic        Mem_We,
  output logic [31:0] Mem_Addr,
  output logic [31:0] Mem_Wdata,
  output logic [3:0]  Mem_Byte_En,
  input  logic        Mem_Ready,
  input  logic [31:0] Mem_Rdata,
  output logic [31:0] Out_RAM_Data,
  output logic        Out_Stall,
  output logic        Out_Bus_Error,
  output logic        Out_Access_Fault
);

  // state  | meaning
  // IDLE   | waiting for a load/store; stall asserted combinationally when one appears
  // ACCESS | bus request outstanding, waiting for Mem_Ready or timeout
  // DONE   | result latched, pipeline released for one cycle
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [15:0] count;
  logic [1:0]  size_q;
  logic        sign_q;
  logic [1:0]  lane_q;

  logic        req_in;
  logic        misalign;
  logic        start;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] rdata_fmt;

  assign req_in = In_MemRead | In_MemWrite;

`ifdef MISALIGN_EXC_EN
  assign misalign = ((In_MemSize == 2'b01) & In_Address[0]) |
                    (In_MemSize[1] & (In_Address[1:0] != 2'b00));
  assign Out_Access_Fault = rst_n & (state == IDLE) & req_in & misalign;
`else
  assign misalign = 1'b0;
  assign Out_Access_Fault = 1'b0;
`endif

  assign start = (state == IDLE) & req_in & ~misalign;
  // Gated by rst_n so a held load/store cannot stall the pipeline during reset.
  assign Out_Stall = rst_n & (start | (state == ACCESS));

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = In_Store_Data;
    case (In_MemSize)
      2'b00: begin
        be_next    = 4'b0001 << In_Address[1:0];
        wdata_next = {4{In_Store_Data[7:0]}};
      end
      2'b01: begin
        be_next    = In_Address[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{In_Store_Data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_sel  = Mem_Rdata[{lane_q, 3'b000} +: 8];
    half_sel  = Mem_Rdata[{lane_q[1], 4'b0000} +: 16];
    rdata_fmt = Mem_Rdata;
    case (size_q)
      2'b00:   rdata_fmt = {{24{sign_q & byte_sel[7]}}, byte_sel};
      2'b01:   rdata_fmt = {{16{sign_q & half_sel[15]}}, half_sel};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      count         <= '0;
      size_q        <= '0;
      sign_q        <= 1'b0;
      lane_q        <= '0;
      Mem_Req       <= 1'b0;
      Mem_We        <= 1'b0;
      Mem_Addr      <= '0;
      Mem_Wdata     <= '0;
      Mem_Byte_En   <= '0;
      Out_RAM_Data  <= '0;
      Out_Bus_Error <= 1'b0;
    end else begin
      Out_Bus_Error <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            size_q      <= In_MemSize;
            sign_q      <= In_MemSigned;
            lane_q      <= In_Address[1:0];
            Mem_We      <= In_MemWrite;
            Mem_Addr    <= {In_Address[31:2], 2'b00};
            Mem_Wdata   <= wdata_next;
            Mem_Byte_En <= be_next;
            Mem_Req     <= 1'b1;
            state       <= ACCESS;
          end else if (req_in & misalign) begin
            Out_RAM_Data <= '0;
          end
        end
        ACCESS: begin
          if (Mem_Ready) begin
            Out_RAM_Data <= Mem_We ? 32'd0 : rdata_fmt;
            Mem_Req      <= 1'b0;
            state        <= DONE;
          end else if (count == TO_LAST) begin
            Out_Bus_Error <= 1'b1;
            Out_RAM_Data  <= '0;
            Mem_Req       <= 1'b0;
            state         <= DONE;
          end else begin
            count <= count + 16'd1;
          end
        end
        DONE: begin
          count <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
